lcd_bus_writer: RTL and testbench

- Consumes 9-bit LCD words over a valid/ready stream from the word generator: bit 8 = RS, bits 7:0 = DB.
- Drives an HD44780-compatible parallel bus in 8-bit, write-only mode.
- Sequences address setup, the E pulse, data hold and the controller execution wait, and holds ready low until the LCD can take another word.
- Last stage before the LCD pins.

---
 rtl/lcd_bus_writer_if.sv | 30 +++
 rtl/lcd_bus_writer.sv | 220 ++++++++++++++++++++++
 tb/tb_lcd_bus_writer.sv | 342 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lcd_bus_writer_if.sv
// Stream-in / LCD-pins-out bundle for lcd_bus_writer.
//   data_i      : 9-bit word, [8] = RS, [7:0] = DB
//   valid_i     : data_i is valid
//   ready_o     : writer can accept a word
//   lcd_rs_o    : LCD register select
//   lcd_rw_o    : LCD read/write, tied to write
//   lcd_e_o     : LCD enable strobe
//   lcd_db_o    : LCD data bus
//   init_done_o : power-up sequence complete
// Modports: master = word source / pin observer, slave = lcd_bus_writer.
interface lcd_bus_writer_if;
    logic [8:0] data_i;
    logic       valid_i;
    logic       ready_o;
    logic       lcd_rs_o;
    logic       lcd_rw_o;
    logic       lcd_e_o;
    logic [7:0] lcd_db_o;
    logic       init_done_o;

    modport master (
        output data_i, valid_i,
        input  ready_o, lcd_rs_o, lcd_rw_o, lcd_e_o, lcd_db_o, init_done_o
    );

    modport slave (
        input  data_i, valid_i,
        output ready_o, lcd_rs_o, lcd_rw_o, lcd_e_o, lcd_db_o, init_done_o
    );
endinterface

// File: rtl/lcd_bus_writer.sv
// HD44780 8-bit write-only bus sequencer. Accepts one 9-bit word (RS + DB) over a
// valid/ready stream and plays it out as setup -> E pulse -> hold -> execution wait,
// keeping ready low until the controller can take another word.
// Ports:
//   clock_i : system clock
//   rstn_i  : asynchronous active-low reset
//   bus     : lcd_bus_writer_if.slave (stream input, LCD pins, init_done_o)
// Optional build macro LCD_INIT_EN: after reset, wait POWERUP_CYC cycles and then
// autonomously write the 8-bit init sequence 38 38 38 0C 01 06 before opening the stream.
module lcd_bus_writer #(
    parameter int unsigned SETUP_CYC   = 2,
    parameter int unsigned PULSE_CYC   = 12,
    parameter int unsigned HOLD_CYC    = 1,
    parameter int unsigned EXEC_CYC    = 2000,
    parameter int unsigned CLEAR_CYC   = 80000,
    parameter int unsigned POWERUP_CYC = 750000,
    parameter int unsigned CNT_W       = 20
) (
    input logic             clock_i,
    input logic             rstn_i,
    lcd_bus_writer_if.slave bus
);

    typedef enum logic [2:0] {
        StIdle,
        StSetup,
        StPulse,
        StHold,
        StWait
`ifdef LCD_INIT_EN
        , StInitWait
`endif
    } state_e;

`ifdef LCD_INIT_EN
    localparam state_e ResetSt = StInitWait;
`else
    localparam state_e ResetSt = StIdle;
`endif

    // Counter reload values: a phase of N cycles counts N-1 down to 0.
    localparam logic [CNT_W-1:0] SetupLd   = CNT_W'(SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] PulseLd   = CNT_W'(PULSE_CYC - 1);
    localparam logic [CNT_W-1:0] HoldLd    = CNT_W'(HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] ExecLd    = CNT_W'(EXEC_CYC - 1);
    localparam logic [CNT_W-1:0] ClearLd   = CNT_W'(CLEAR_CYC - 1);
    localparam logic [CNT_W-1:0] PowerupLd = CNT_W'(POWERUP_CYC - 1);

    localparam longint unsigned MaxCyc =
        longint'(SETUP_CYC) > longint'(PULSE_CYC) ? longint'(SETUP_CYC) : longint'(PULSE_CYC);
    localparam longint unsigned MaxCyc2 = MaxCyc > longint'(HOLD_CYC) ? MaxCyc : longint'(HOLD_CYC);
    localparam longint unsigned MaxCyc3 = MaxCyc2 > longint'(EXEC_CYC) ? MaxCyc2 : longint'(EXEC_CYC);
    localparam longint unsigned MaxCyc4 =
        MaxCyc3 > longint'(CLEAR_CYC) ? MaxCyc3 : longint'(CLEAR_CYC);
    localparam longint unsigned MaxCyc5 =
        MaxCyc4 > longint'(POWERUP_CYC) ? MaxCyc4 : longint'(POWERUP_CYC);

    if (MaxCyc5 > (longint'(1) << CNT_W)) begin : g_cnt_w_check
        $error("CNT_W too narrow for the largest timing parameter");
    end

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             rs_q, rs_d;
    logic [7:0]       db_q, db_d;
    logic             e_q, e_d;
    logic             ready_q, ready_d;
    logic             init_done_q, init_done_d;
    logic             is_clear;
    logic [CNT_W-1:0] wait_ld;

`ifdef LCD_INIT_EN
    logic [2:0] init_idx_q, init_idx_d;
    logic       init_act_q, init_act_d;

    function automatic logic [7:0] init_word(input logic [2:0] idx);
        unique case (idx)
            3'd0, 3'd1, 3'd2: init_word = 8'h38;  // function set, 8-bit, 2 lines
            3'd3:             init_word = 8'h0C;  // display on
            3'd4:             init_word = 8'h01;  // clear
            default:          init_word = 8'h06;  // entry mode, increment
        endcase
    endfunction
`endif

    // Clear Display (01) and Return Home (02/03) need the long execution wait.
    always_comb begin
        is_clear = !rs_q && (db_q[7:2] == 6'd0) && (db_q[1:0] != 2'd0);
        wait_ld  = is_clear ? ClearLd : ExecLd;
`ifdef LCD_INIT_EN
        if (init_act_q && (init_idx_q == 3'd0)) begin
            wait_ld = PowerupLd;
        end
`endif
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rs_d        = rs_q;
        db_d        = db_q;
`ifdef LCD_INIT_EN
        init_idx_d  = init_idx_q;
        init_act_d  = init_act_q;
        init_done_d = init_done_q;
`else
        init_done_d = 1'b1;
`endif

        unique case (state_q)
            StIdle: begin
                if (bus.valid_i && ready_q) begin
                    rs_d    = bus.data_i[8];
                    db_d    = bus.data_i[7:0];
                    cnt_d   = SetupLd;
                    state_d = StSetup;
                end
            end
            StSetup: begin
                if (cnt_q == '0) begin
                    cnt_d   = PulseLd;
                    state_d = StPulse;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StPulse: begin
                if (cnt_q == '0) begin
                    cnt_d   = HoldLd;
                    state_d = StHold;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StHold: begin
                if (cnt_q == '0) begin
                    cnt_d   = wait_ld;
                    state_d = StWait;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StWait: begin
                if (cnt_q == '0) begin
                    state_d = StIdle;
`ifdef LCD_INIT_EN
                    if (init_act_q) begin
                        if (init_idx_q == 3'd5) begin
                            init_act_d  = 1'b0;
                            init_done_d = 1'b1;
                        end else begin
                            init_idx_d = init_idx_q + 3'd1;
                            rs_d       = 1'b0;
                            db_d       = init_word(init_idx_q + 3'd1);
                            cnt_d      = SetupLd;
                            state_d    = StSetup;
                        end
                    end
`endif
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
`ifdef LCD_INIT_EN
            // Reset leaves the counter at 0, so the power-up delay counts up instead.
            StInitWait: begin
                if (cnt_q == PowerupLd) begin
                    rs_d    = 1'b0;
                    db_d    = init_word(3'd0);
                    cnt_d   = SetupLd;
                    state_d = StSetup;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
`endif
            default: state_d = StIdle;
        endcase

        // Registered pin outputs follow the next state so they line up with it.
        ready_d = (state_d == StIdle);
        e_d     = (state_d == StPulse);
    end

    always_ff @(posedge clock_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q     <= ResetSt;
            cnt_q       <= '0;
            rs_q        <= 1'b0;
            db_q        <= 8'h00;
            e_q         <= 1'b0;
            ready_q     <= 1'b0;
            init_done_q <= 1'b0;
`ifdef LCD_INIT_EN
            init_idx_q  <= 3'd0;
            init_act_q  <= 1'b1;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rs_q        <= rs_d;
            db_q        <= db_d;
            e_q         <= e_d;
            ready_q     <= ready_d;
            init_done_q <= init_done_d;
`ifdef LCD_INIT_EN
            init_idx_q  <= init_idx_d;
            init_act_q  <= init_act_d;
`endif
        end
    end

    assign bus.ready_o     = ready_q;
    assign bus.lcd_rs_o    = rs_q;
    assign bus.lcd_rw_o    = 1'b0;
    assign bus.lcd_e_o     = e_q;
    assign bus.lcd_db_o    = db_q;
    assign bus.init_done_o = init_done_q;

endmodule

// File: tb/tb_lcd_bus_writer.sv
// Self-checking bench for lcd_bus_writer: timing of each word against a cycle-count
// model, back-to-back streaming, asynchronous reset mid-pulse and (with LCD_INIT_EN)
// the autonomous power-up sequence.
`timescale 1ns/1ps
module tb_lcd_bus_writer;

    localparam int SETUP   = 2;
    localparam int PULSE   = 3;
    localparam int HOLD    = 1;
    localparam int EXEC    = 5;
    localparam int CLEAR   = 20;
    localparam int POWERUP = 30;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    lcd_bus_writer_if bus();

    lcd_bus_writer #(
        .SETUP_CYC  (SETUP),
        .PULSE_CYC  (PULSE),
        .HOLD_CYC   (HOLD),
        .EXEC_CYC   (EXEC),
        .CLEAR_CYC  (CLEAR),
        .POWERUP_CYC(POWERUP),
        .CNT_W      (20)
    ) dut (
        .clock_i(clk),
        .rstn_i (rstn),
        .bus    (bus)
    );

    int checks = 0;
    int errors = 0;

    // Words seen on the pins at each E rising edge.
    logic [8:0] e_words[$];
    logic       e_prev = 1'b0;
    always @(negedge clk) begin
        if (bus.lcd_e_o === 1'b1 && e_prev !== 1'b1) e_words.push_back({bus.lcd_rs_o, bus.lcd_db_o});
        e_prev = bus.lcd_e_o;
    end

    // Reference model: execution wait of a word, and total busy time after an accept.
    function automatic int exp_wait(input logic [8:0] w);
        if (w[8] == 1'b0 && w[7:0] >= 8'd1 && w[7:0] <= 8'd3) return CLEAR;
        return EXEC;
    endfunction

    function automatic int busy_len(input logic [8:0] w);
        return SETUP + PULSE + HOLD + exp_wait(w);
    endfunction

    task automatic wait_ready(input string name);
        int n = 0;
        while (bus.ready_o !== 1'b1 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (bus.ready_o !== 1'b1) begin
            errors++;
            $display("FAIL %s_ready_timeout: ready=%b required 1", name, bus.ready_o);
        end
    endtask

    // Sends one word and measures ready-low time, E width and E start offset.
    task automatic run_word(input logic [8:0] w, input string name);
        int low = 0, ehigh = 0, efirst = -1, cyc = 0, bad_bus = 0;
        wait_ready(name);
        bus.data_i  = w;
        bus.valid_i = 1'b1;
        @(negedge clk);
        bus.valid_i = 1'b0;
        bus.data_i  = 9'($urandom);
        checks++;
        if ({bus.lcd_rs_o, bus.lcd_db_o} !== w) begin
            errors++;
            $display("FAIL %s_bus_after_accept: got %h required %h", name,
                     {bus.lcd_rs_o, bus.lcd_db_o}, w);
        end
        while (bus.ready_o !== 1'b1 && cyc < 1000) begin
            if (bus.lcd_e_o === 1'b1) begin
                ehigh++;
                if (efirst < 0) efirst = cyc;
            end
            if ({bus.lcd_rs_o, bus.lcd_db_o} !== w || bus.lcd_rw_o !== 1'b0) bad_bus++;
            low++;
            cyc++;
            @(negedge clk);
        end
        checks++;
        if (low != busy_len(w)) begin
            errors++;
            $display("FAIL %s_ready_low: got %0d cycles required %0d", name, low, busy_len(w));
        end
        checks++;
        if (ehigh != PULSE) begin
            errors++;
            $display("FAIL %s_e_width: got %0d required %0d", name, ehigh, PULSE);
        end
        checks++;
        if (efirst != SETUP) begin
            errors++;
            $display("FAIL %s_e_start: got %0d required %0d", name, efirst, SETUP);
        end
        checks++;
        if (bad_bus != 0) begin
            errors++;
            $display("FAIL %s_bus_stable: got %0d unstable cycles required 0", name, bad_bus);
        end
        checks++;
        if ({bus.lcd_rs_o, bus.lcd_db_o} !== w || bus.lcd_e_o !== 1'b0) begin
            errors++;
            $display("FAIL %s_bus_idle: got rsdb=%h e=%b required rsdb=%h e=0", name,
                     {bus.lcd_rs_o, bus.lcd_db_o}, bus.lcd_e_o, w);
        end
    endtask

    task automatic test_reset();
        logic exp_run;
        bus.valid_i = 1'b0;
        bus.data_i  = 9'h000;
        rstn        = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if ({bus.ready_o, bus.lcd_e_o, bus.lcd_rs_o, bus.lcd_rw_o, bus.init_done_o} !== 5'b0 ||
            bus.lcd_db_o !== 8'h00) begin
            errors++;
            $display("FAIL reset_held: got rdy=%b e=%b rs=%b rw=%b done=%b db=%h required all 0",
                     bus.ready_o, bus.lcd_e_o, bus.lcd_rs_o, bus.lcd_rw_o, bus.init_done_o,
                     bus.lcd_db_o);
        end
        rstn = 1'b1;
        @(negedge clk);
`ifdef LCD_INIT_EN
        exp_run = 1'b0;
`else
        exp_run = 1'b1;
`endif
        checks++;
        if (bus.ready_o !== exp_run) begin
            errors++;
            $display("FAIL reset_ready_cycle1: got %b required %b", bus.ready_o, exp_run);
        end
        checks++;
        if (bus.init_done_o !== exp_run) begin
            errors++;
            $display("FAIL reset_init_done: got %b required %b", bus.init_done_o, exp_run);
        end
        checks++;
        if (bus.lcd_e_o !== 1'b0 || bus.lcd_rs_o !== 1'b0 || bus.lcd_db_o !== 8'h00 ||
            bus.lcd_rw_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_bus: got e=%b rs=%b db=%h rw=%b required 0 0 00 0",
                     bus.lcd_e_o, bus.lcd_rs_o, bus.lcd_db_o, bus.lcd_rw_o);
        end
    endtask

`ifdef LCD_INIT_EN
    task automatic test_init();
        logic [8:0] exp_w[6];
        int k = 0, first_e = -1, done_k = -1, together_bad = 0, exp_done;
        exp_w[0] = 9'h038; exp_w[1] = 9'h038; exp_w[2] = 9'h038;
        exp_w[3] = 9'h00C; exp_w[4] = 9'h001; exp_w[5] = 9'h006;
        exp_done = POWERUP;
        for (int i = 0; i < 6; i++) begin
            exp_done += SETUP + PULSE + HOLD + ((i == 0) ? POWERUP : exp_wait(exp_w[i]));
        end
        bus.valid_i = 1'b0;
        rstn = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        e_words.delete();
        bus.valid_i = 1'b1;
        bus.data_i  = 9'($urandom);
        while (k < 1000) begin
            @(negedge clk);
            k++;
            if (bus.lcd_e_o === 1'b1 && first_e < 0) first_e = k;
            if (bus.ready_o !== bus.init_done_o) together_bad++;
            bus.data_i = 9'($urandom);
            if (bus.init_done_o === 1'b1) begin
                done_k      = k;
                bus.valid_i = 1'b0;
                break;
            end
        end
        checks++;
        if (first_e != POWERUP + SETUP) begin
            errors++;
            $display("FAIL init_first_e: got cycle %0d required %0d", first_e, POWERUP + SETUP);
        end
        checks++;
        if (done_k != exp_done) begin
            errors++;
            $display("FAIL init_done_cycle: got %0d required %0d", done_k, exp_done);
        end
        checks++;
        if (together_bad != 0) begin
            errors++;
            $display("FAIL init_ready_with_done: got %0d split cycles required 0", together_bad);
        end
        checks++;
        if (e_words.size() != 6) begin
            errors++;
            $display("FAIL init_word_count: got %0d required 6", e_words.size());
        end else begin
            for (int i = 0; i < 6; i++) begin
                checks++;
                if (e_words[i] !== exp_w[i]) begin
                    errors++;
                    $display("FAIL init_word%0d: got %h required %h", i, e_words[i], exp_w[i]);
                end
            end
        end
    endtask
`endif

    task automatic test_single();
        run_word(9'h141, "w141");
    endtask

    task automatic test_clear_wait();
        run_word(9'h001, "w001");
        run_word(9'h003, "w003");
        run_word(9'h004, "w004");
    endtask

    task automatic test_random();
        logic [8:0] w;
        for (int i = 0; i < 8; i++) begin
            w = 9'($urandom);
            if ($urandom_range(0, 2) == 0) w = {1'b0, 8'($urandom_range(0, 4))};
            run_word(w, $sformatf("rand%0d", i));
        end
    endtask

    task automatic test_back_to_back();
        logic [8:0] base;
        logic       pend;
        int n_acc = 0, last_acc = -1, cyc = 0, bad_gap = 0;
        wait_ready("b2b");
        e_words.delete();
        base        = {1'b1, 8'($urandom_range(0, 200))};
        bus.data_i  = base;
        bus.valid_i = 1'b1;
        while (n_acc < 5 && cyc < 500) begin
            pend = (bus.ready_o === 1'b1);
            @(negedge clk);
            cyc++;
            if (pend) begin
                if (last_acc >= 0 && (cyc - last_acc) != busy_len(base) + 1) bad_gap++;
                last_acc = cyc;
                n_acc++;
                bus.data_i = bus.data_i + 9'd1;
                if (n_acc == 5) bus.valid_i = 1'b0;
            end
        end
        bus.valid_i = 1'b0;
        wait_ready("b2b_end");
        checks++;
        if (n_acc != 5) begin
            errors++;
            $display("FAIL b2b_accepts: got %0d required 5", n_acc);
        end
        checks++;
        if (bad_gap != 0) begin
            errors++;
            $display("FAIL b2b_spacing: got %0d bad gaps required 0 (gap %0d)", bad_gap,
                     busy_len(base) + 1);
        end
        checks++;
        if (e_words.size() != 5) begin
            errors++;
            $display("FAIL b2b_word_count: got %0d required 5", e_words.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                checks++;
                if (e_words[i] !== base + 9'(i)) begin
                    errors++;
                    $display("FAIL b2b_word%0d: got %h required %h", i, e_words[i], base + 9'(i));
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        int n = 0;
        wait_ready("rmid");
        bus.data_i  = 9'h1A5;
        bus.valid_i = 1'b1;
        @(negedge clk);
        bus.valid_i = 1'b0;
        while (bus.lcd_e_o !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (bus.lcd_e_o !== 1'b1) begin
            errors++;
            $display("FAIL rmid_e_seen: got %b required 1", bus.lcd_e_o);
        end
        #2 rstn = 1'b0;
        #1;
        checks++;
        if (bus.lcd_e_o !== 1'b0 || bus.lcd_rs_o !== 1'b0 || bus.lcd_db_o !== 8'h00 ||
            bus.ready_o !== 1'b0) begin
            errors++;
            $display("FAIL rmid_async_clear: got e=%b rs=%b db=%h rdy=%b required 0 0 00 0",
                     bus.lcd_e_o, bus.lcd_rs_o, bus.lcd_db_o, bus.ready_o);
        end
        @(negedge clk);
        rstn = 1'b1;
        run_word({1'b1, 8'($urandom)}, "rmid_after");
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.valid_i = 1'b0;
        bus.data_i  = 9'h000;
        test_reset();
`ifdef LCD_INIT_EN
        test_init();
`endif
        test_single();
        test_clear_wait();
        test_random();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
